dmem_mmio: RTL and testbench
============================

Name: dmem_mmio

Overview:
- Data-side memory stage directly downstream of the single-cycle core. Consumes the core's MemWrite, OPResult (used as the address) and WriteData, and returns ReadData.
- Holds the word-addressed data RAM.
- Holds a small memory-mapped I/O page: a console transmit FIFO drained over a valid/ready byte stream, a status register, and a free-running cycle counter.
- Reads are combinational, so the single-cycle core completes a load in the same cycle.

Parameters:
- MEM_WORDS, 64, number of 32-bit data RAM words; power of two.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16.
- IO_PAGE, 16'hFFFF, value of addr[31:16] that selects the I/O page.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- we  in  1  store enable, from the core's MemWrite.
- addr  in  32  byte address, from the core's OPResult; bits [1:0] ignored.
- wdata  in  32  store data, from the core's WriteData.
- rdata  out  32  load data, combinational, to the core's ReadData.
- tx_valid  out  1  FIFO head byte is available.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready at a rising clk edge.

Behaviour:
- Address decode:
  - io_sel = (addr[31:16] == IO_PAGE); otherwise the access goes to RAM.
  - RAM index = addr[log2(MEM_WORDS)+1:2]. Upper bits are ignored, so out-of-range addresses alias and wrap.
- RAM:
  - Write on rising clk when we && !io_sel.
  - rdata is combinational from the current index.
  - RAM is not reset; contents are undefined until written.
  - A write followed by a read of the same word in the next cycle returns the new data.
- I/O registers, selected by offset addr[7:0]. Any other offset reads 0 and ignores writes.
  - 0x00 TXDATA:
    - A write pushes wdata[7:0] if the FIFO is not full.
    - A write while full is dropped and sets the sticky ovf flag.
    - Reads return 0.
  - 0x04 STATUS (read):
    - bit0 = full, bit1 = empty, bit2 = ovf, bits[8:4] = count (0..FIFO_DEPTH), all other bits 0.
    - Writing 1 to bit2 clears ovf. A clear and a new overflow in the same cycle leaves ovf = 1.
  - 0x08 CYCLES:
    - 32-bit counter, increments every cycle and wraps from FFFF_FFFF to 0.
    - Any write loads 0; on a write, the load wins over the increment.
    - Reads return the current value.
- TX FIFO:
  - Circular buffer with read/write pointers and a count.
  - tx_valid = !empty; tx_data = mem[rd_ptr].
  - Pop occurs when tx_valid && tx_ready.
  - Push and pop in the same cycle:
    - Not full and not empty: both take effect, count unchanged.
    - Full: the pop frees a slot, so the push is accepted and no ovf is set.
    - Empty: only the push occurs, since there is no pop from empty.
  - Pointers wrap modulo FIFO_DEPTH.
  - Latency: a byte pushed at edge N is presented with tx_valid = 1 after edge N.
- Reset (async assert, sync release):
  - FIFO pointers and count = 0, so tx_valid = 0 and tx_data = FIFO mem[0] (unreset, undefined).
  - ovf = 0; CYCLES = 0.
  - rdata follows the decode combinationally; RAM is unchanged.
  - Reset mid-stream discards all queued bytes.
- tx_data may change only while tx_valid = 0 or after a pop. The head is stable while tx_valid && !tx_ready.

Decomposition:
- Package dmem_mmio_pkg:
  - Offset constants OFF_TXDATA = 8'h00, OFF_STATUS = 8'h04, OFF_CYCLES = 8'h08.
  - STATUS bit positions.
  - Default IO_PAGE.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Ports: push, din, pop, dout, full, empty, count.
  - Same async active-low reset.
  - dmem_mmio owns the ovf and full-with-pop acceptance logic.

Test Plan:
1. RAM: write 0xDEADBEEF to addr 0x10, then read 0x10 -> rdata = 0xDEADBEEF. Read 0x110 (MEM_WORDS = 64 alias) -> 0xDEADBEEF.
2. FIFO fill: with tx_ready = 0, write 0x41, 0x42, 0x43, 0x44 to 0xFFFF0000 -> STATUS = 0x41 (count 4, full). A fifth write of 0x45 -> STATUS = 0x45 (ovf set) and the FIFO still holds 0x41..0x44.
3. Drain: raise tx_ready -> tx_data = 0x41, 0x42, 0x43, 0x44 on successive cycles, then tx_valid = 0 and STATUS = 0x06. Write 0x4 to 0xFFFF0004 -> STATUS = 0x02.
4. Full with simultaneous push and pop: FIFO full and tx_ready = 1, write 0x55 -> count stays 4, ovf stays 0, and 0x55 emerges last.
5. Counter: write 0 to 0xFFFF0008, then read after 10 cycles -> 10. Force the counter to 0xFFFFFFFF -> it reads 0 one cycle later.
6. Reset mid-operation: with 3 bytes queued and CYCLES = 1234, pull reset to 0 asynchronously (between edges) -> tx_valid = 0 immediately. After release, STATUS = 0x02 and CYCLES counts from 0.

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg: shared constants for the data-memory / MMIO stage.
//   - I/O register offsets within the I/O page
//   - STATUS register bit positions
//   - default I/O page selector
//   - pack_status(): builds the STATUS read word
package dmem_mmio_pkg;

  localparam logic [15:0] DEF_IO_PAGE = 16'hFFFF;

  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CYCLES = 8'h08;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_CNT_LO = 4;
  localparam int ST_CNT_HI = 8;

  function automatic logic [31:0] pack_status(input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [4:0] cnt);
    logic [31:0] s;
    s = '0;
    s[ST_FULL]             = full;
    s[ST_EMPTY]            = empty;
    s[ST_OVF]              = ovf;
    s[ST_CNT_HI:ST_CNT_LO] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/dmem_mmio_fifo.sv
// sync_fifo: circular-buffer FIFO, combinational head output.
//   clk, reset (async, active low)
//   push/din  : write din at the tail; caller only pushes when a slot exists
//               (not full, or full with a pop in the same cycle)
//   pop       : drop the head; caller only pops when not empty
//   dout      : current head entry (storage itself is not reset)
//   full, empty, count (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  // When full, wr_ptr == rd_ptr: a simultaneous pop consumes the old head at
  // this edge while the push overwrites that same slot.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data memory stage for the single-cycle core.
//   clk, reset (async, active low)
//   we, addr, wdata : store enable / byte address / store data from the core
//   rdata           : combinational load data back to the core
//   tx_valid/tx_data/tx_ready : console byte stream out of the TX FIFO
// addr[31:16] == IO_PAGE selects the I/O page (TXDATA, STATUS, CYCLES by
// addr[7:0]); everything else is the word-addressed RAM, which wraps.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          MEM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] IO_PAGE    = DEF_IO_PAGE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------- decode ----------------
  logic          io_sel;
  logic [7:0]    off;
  logic [AW-1:0] idx;

  assign io_sel = (addr[31:16] == IO_PAGE);
  assign off    = addr[7:0];
  assign idx    = addr[AW+1:2];

  logic wr_tx, wr_status, wr_cycles;
  assign wr_tx     = we && io_sel && (off == OFF_TXDATA);
  assign wr_status = we && io_sel && (off == OFF_STATUS);
  assign wr_cycles = we && io_sel && (off == OFF_CYCLES);

  // ---------------- RAM ----------------
  logic [31:0] ram [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we && !io_sel) ram[idx] <= wdata;
  end

  // ---------------- TX FIFO ----------------
  logic          f_full, f_empty, f_pop, f_push;
  logic [CW-1:0] f_count;

  assign tx_valid = !f_empty;
  assign f_pop    = tx_valid && tx_ready;
  // A pop on a full FIFO frees the slot this push lands in.
  assign f_push   = wr_tx && (!f_full || f_pop);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txq (
    .clk   (clk),
    .reset (reset),
    .push  (f_push),
    .din   (wdata[7:0]),
    .pop   (f_pop),
    .dout  (tx_data),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  // ---------------- ovf / cycle counter ----------------
  logic        ovf;
  logic        ovf_set, ovf_clr;
  logic [31:0] cycles;

  assign ovf_set = wr_tx && !f_push;
  assign ovf_clr = wr_status && wdata[ST_OVF];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf    <= 1'b0;
      cycles <= '0;
    end else begin
      // set beats clear when both land in one cycle
      ovf    <= ovf_set || (ovf && !ovf_clr);
      cycles <= wr_cycles ? '0 : cycles + 32'd1;
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    rdata = '0;
    if (io_sel) begin
      case (off)
        OFF_STATUS: rdata = pack_status(f_full, f_empty, ovf, 5'(f_count));
        OFF_CYCLES: rdata = cycles;
        default:    rdata = '0;
      endcase
    end else begin
      rdata = ram[idx];
    end
  end

  // addr[15:8] play no part in decode; [1:0] are the byte lane.
  logic unused_addr;
  assign unused_addr = &{1'b0, addr[15:8], addr[1:0]};

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  dmem_mmio #(.MEM_WORDS(64), .FIFO_DEPTH(4), .IO_PAGE(16'hFFFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_ST  = 32'hFFFF_0004;
  localparam logic [31:0] A_CY  = 32'hFFFF_0008;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic        cr;   // compare rdata
    logic [31:0] er;
    logic        ev;   // expected tx_valid (always compared)
    logic [7:0]  ed;   // expected tx_data when ev
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic w, logic [31:0] a, logic [31:0] d, logic r,
                              logic cr, logic [31:0] er, logic ev, logic [7:0] ed);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.rdy = r;
    v.cr = cr; v.er = er; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    we = 1'b0; addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  initial begin
    // ---- vector table: RAM, FIFO fill/overflow, drain, full push+pop ----
    vt.push_back(mk(1, 32'h10,  32'hDEAD_BEEF, 0, 0, 0,            0, 0));
    vt.push_back(mk(0, 32'h10,  0,             0, 1, 32'hDEAD_BEEF, 0, 0));
    vt.push_back(mk(0, 32'h110, 0,             0, 1, 32'hDEAD_BEEF, 0, 0));
    vt.push_back(mk(1, 32'h20,  32'h1234_5678, 0, 0, 0,            0, 0));
    vt.push_back(mk(0, 32'h20,  0,             0, 1, 32'h1234_5678, 0, 0));
    vt.push_back(mk(0, 32'h10,  0,             0, 1, 32'hDEAD_BEEF, 0, 0));
    vt.push_back(mk(1, A_TX, 32'h41, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, A_TX, 32'h42, 0, 0, 0, 1, 8'h41));
    vt.push_back(mk(1, A_TX, 32'h43, 0, 0, 0, 1, 8'h41));
    vt.push_back(mk(1, A_TX, 32'h44, 0, 0, 0, 1, 8'h41));
    vt.push_back(mk(0, A_ST, 0,      0, 1, 32'h41, 1, 8'h41));
    vt.push_back(mk(1, A_TX, 32'h45, 0, 0, 0,      1, 8'h41));
    vt.push_back(mk(0, A_ST, 0,      0, 1, 32'h45, 1, 8'h41));
    vt.push_back(mk(0, A_TX, 0,      0, 1, 32'h00, 1, 8'h41));
    vt.push_back(mk(0, 32'hFFFF_000C, 0, 0, 1, 32'h00, 1, 8'h41));
    vt.push_back(mk(0, A_ST, 0, 1, 1, 32'h45, 1, 8'h41));
    vt.push_back(mk(0, A_ST, 0, 1, 1, 32'h34, 1, 8'h42));
    vt.push_back(mk(0, A_ST, 0, 1, 1, 32'h24, 1, 8'h43));
    vt.push_back(mk(0, A_ST, 0, 1, 1, 32'h14, 1, 8'h44));
    vt.push_back(mk(0, A_ST, 0, 1, 1, 32'h06, 0, 0));
    vt.push_back(mk(1, A_ST, 32'h4, 0, 1, 32'h06, 0, 0));
    vt.push_back(mk(0, A_ST, 0,     0, 1, 32'h02, 0, 0));
    vt.push_back(mk(1, A_TX, 32'h61, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, A_TX, 32'h62, 0, 0, 0, 1, 8'h61));
    vt.push_back(mk(1, A_TX, 32'h63, 0, 0, 0, 1, 8'h61));
    vt.push_back(mk(1, A_TX, 32'h64, 0, 0, 0, 1, 8'h61));
    vt.push_back(mk(1, A_TX, 32'h55, 1, 0, 0, 1, 8'h61));
    vt.push_back(mk(0, A_ST, 0, 0, 1, 32'h41, 1, 8'h62));
    vt.push_back(mk(0, A_ST, 0, 1, 1, 32'h41, 1, 8'h62));
    vt.push_back(mk(0, A_ST, 0, 1, 1, 32'h30, 1, 8'h63));
    vt.push_back(mk(0, A_ST, 0, 1, 1, 32'h20, 1, 8'h64));
    vt.push_back(mk(0, A_ST, 0, 1, 1, 32'h10, 1, 8'h55));
    vt.push_back(mk(0, A_ST, 0, 0, 1, 32'h02, 0, 0));
    vt.push_back(mk(1, 32'hFFFF_0010, 32'h99, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0, 0));

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #2;
    rd_chk("rst status", A_ST, 32'h02);
    chk("rst tx_valid", {31'b0, tx_valid}, 32'h0);
    rd_chk("rst cycles", A_CY, 32'h0);
    reset = 1'b1;
    cyc();

    // ---- table ----
    foreach (vt[i]) begin
      we = vt[i].we; addr = vt[i].addr; wdata = vt[i].wdata; tx_ready = vt[i].rdy;
      #1;
      if (vt[i].cr) chk($sformatf("vec%0d rdata", i), rdata, vt[i].er);
      chk($sformatf("vec%0d tx_valid", i), {31'b0, tx_valid}, {31'b0, vt[i].ev});
      if (vt[i].ev) chk($sformatf("vec%0d tx_data", i), {24'b0, tx_data}, {24'b0, vt[i].ed});
      cyc();
    end
    we = 1'b0; tx_ready = 1'b0;

    // ---- cycle counter: load, count, wrap ----
    wr(A_CY, 32'h1234);
    repeat (10) cyc();
    rd_chk("cycles +10", A_CY, 32'd10);
    force dut.cycles = 32'hFFFF_FFFF;
    #1;
    release dut.cycles;
    #1;
    chk("cycles forced", rdata, 32'hFFFF_FFFF);
    cyc();
    rd_chk("cycles wrap", A_CY, 32'h0);

    // ---- async reset mid-stream ----
    wr(A_CY, 32'h0);
    wr(A_TX, 32'h71);
    wr(A_TX, 32'h72);
    wr(A_TX, 32'h73);
    repeat (1231) cyc();
    rd_chk("pre-rst cycles", A_CY, 32'd1234);
    rd_chk("pre-rst status", A_ST, 32'h30);
    chk("pre-rst tx_data", {24'b0, tx_data}, 32'h71);
    #3;
    reset = 1'b0;
    #1;
    chk("async rst tx_valid", {31'b0, tx_valid}, 32'h0);
    rd_chk("in-rst status", A_ST, 32'h02);
    rd_chk("in-rst cycles", A_CY, 32'h0);
    cyc();
    cyc();
    reset = 1'b1;
    rd_chk("post-rst cycles", A_CY, 32'h0);
    cyc();
    rd_chk("post-rst cycles+1", A_CY, 32'd1);
    rd_chk("post-rst status", A_ST, 32'h02);
    chk("post-rst tx_valid", {31'b0, tx_valid}, 32'h0);
    rd_chk("ram kept over rst", 32'h10, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
